// File: rtl/mem_access_unit.sv
// Load/store unit: aligns requests onto a DATA_W-wide bus, checks alignment and
// size, bounds the wait for mem_ack and returns extended load data.
module mem_access_unit #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic                  flush,
  output logic                  stall,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic [1:0]            resp_err,
  output logic [ADDR_W-1:0]     badvaddr,
  output logic                  mem_en,
  output logic [DATA_W/8-1:0]   mem_wen,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned CNT_W = (TO_W > 10) ? TO_W : 10;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          size_q;
  logic                we_q;
  logic                sgn_q;
  logic                kill_q;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_inc;
  logic                timeout_hit;
  logic                accept;
  logic                size_bad;
  logic                misal;
  logic [2:0]          low_mask;
  logic [NB-1:0]       size_mask;
  logic [NB-1:0]       wen_nxt;
  logic [DATA_W-1:0]   wdata_rep;
  logic [DATA_W-1:0]   shifted;
  logic [DATA_W-1:0]   ext_mask;
  logic                ext_msb;
  logic [DATA_W-1:0]   load_ext;

  assign accept      = (state == IDLE) && req_valid && !flush;
  assign size_bad    = (DATA_W == 32) && (req_size == 2'd3);
  assign misal       = (req_addr[2:0] & low_mask) != 3'b000;
  assign cnt_inc     = cnt + CNT_W'(1);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; a same-cycle ack takes priority over the timeout
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (size_bad || misal) ? RESP : BUS;
      BUS:     if (mem_ack || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state; stall is held low while in reset
  always_comb begin
    req_ready  = (state == IDLE);
    mem_en     = (state == BUS);
    stall      = rst && (accept || (state == BUS));
    resp_valid = (state == RESP) && !kill_q && !flush;
  end

  // Store formatting: alignment mask, lane strobes and lane-replicated data
  always_comb begin
    low_mask  = 3'b000;
    size_mask = NB'(1);
    wdata_rep = req_wdata;
    case (req_size)
      2'd0: begin
        low_mask  = 3'b000;
        size_mask = NB'(8'h01);
        wdata_rep = {NB{req_wdata[7:0]}};
      end
      2'd1: begin
        low_mask  = 3'b001;
        size_mask = NB'(8'h03);
        wdata_rep = {(NB/2){req_wdata[15:0]}};
      end
      2'd2: begin
        low_mask  = 3'b011;
        size_mask = NB'(8'h0F);
        wdata_rep = {(NB/4){req_wdata[31:0]}};
      end
      default: begin
        low_mask  = 3'b111;
        size_mask = NB'(8'hFF);
        wdata_rep = req_wdata;
      end
    endcase
    wen_nxt = req_we ? (size_mask << req_addr[OFF_W-1:0]) : '0;
  end

  // Load formatting: shift the addressed lanes down, then sign/zero extend
  always_comb begin
    shifted = mem_rdata >> {addr_q[OFF_W-1:0], 3'b000};
    case (size_q)
      2'd0:    begin ext_mask = DATA_W'(64'h0000_0000_0000_00FF); ext_msb = shifted[7];  end
      2'd1:    begin ext_mask = DATA_W'(64'h0000_0000_0000_FFFF); ext_msb = shifted[15]; end
      2'd2:    begin ext_mask = DATA_W'(64'h0000_0000_FFFF_FFFF); ext_msb = shifted[31]; end
      default: begin ext_mask = '1;                                ext_msb = shifted[DATA_W-1]; end
    endcase
    load_ext = (shifted & ext_mask) | ({DATA_W{sgn_q & ext_msb}} & ~ext_mask);
  end

  // Request latch, bus drive, wait counter and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q     <= '0;
      size_q     <= 2'd0;
      we_q       <= 1'b0;
      sgn_q      <= 1'b0;
      kill_q     <= 1'b0;
      cnt        <= '0;
      mem_addr   <= '0;
      mem_wen    <= '0;
      mem_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 2'd0;
      badvaddr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q <= req_addr;
            size_q <= req_size;
            we_q   <= req_we;
            sgn_q  <= req_signed;
            kill_q <= 1'b0;
            cnt    <= '0;
            if (size_bad) begin
              resp_err   <= 2'd3;
              badvaddr   <= req_addr;
              resp_rdata <= '0;
            end else if (misal) begin
              resp_err   <= 2'd1;
              badvaddr   <= req_addr;
              resp_rdata <= '0;
            end else begin
              mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              mem_wen   <= wen_nxt;
              mem_wdata <= wdata_rep;
            end
          end
        end
        BUS: begin
          cnt <= cnt_inc;
          if (flush) kill_q <= 1'b1;
          if (mem_ack) begin
            resp_err   <= 2'd0;
            badvaddr   <= '0;
            resp_rdata <= we_q ? '0 : load_ext;
          end else if (timeout_hit) begin
            resp_err   <= 2'd2;
            badvaddr   <= addr_q;
            resp_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a 32-bit instance (TIMEOUT=4) and a
// 64-bit instance, with expected responses queued and checked by monitors.
module tb_mem_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_we, req_signed, flush, mem_ack;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, mem_rdata;
  logic        req_ready, stall, resp_valid, mem_en;
  logic [1:0]  resp_err;
  logic [31:0] resp_rdata, badvaddr, mem_addr, mem_wdata;
  logic [3:0]  mem_wen;

  logic        w_req_valid, w_mem_ack;
  logic [63:0] w_req_wdata, w_mem_rdata;
  logic        w_req_ready, w_stall, w_resp_valid, w_mem_en;
  logic [1:0]  w_resp_err;
  logic [63:0] w_resp_rdata, w_mem_wdata;
  logic [31:0] w_badvaddr, w_mem_addr;
  logic [7:0]  w_mem_wen;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) u32 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush), .stall(stall),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .badvaddr(badvaddr), .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  mem_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(4)) u64 (
    .clk(clk), .rst(rst), .req_valid(w_req_valid), .req_ready(w_req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(w_req_wdata), .flush(flush), .stall(w_stall),
    .resp_valid(w_resp_valid), .resp_rdata(w_resp_rdata), .resp_err(w_resp_err),
    .badvaddr(w_badvaddr), .mem_en(w_mem_en), .mem_wen(w_mem_wen), .mem_addr(w_mem_addr),
    .mem_wdata(w_mem_wdata), .mem_rdata(w_mem_rdata), .mem_ack(w_mem_ack)
  );

  typedef struct {
    logic [63:0] rdata;
    logic [1:0]  err;
    logic [31:0] bad;
    int          id;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  exp_t e32, e64;
  int   total  = 0;
  int   passed = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  // Monitor for the 32-bit unit
  always @(negedge clk) begin
    if (rst === 1'b1 && resp_valid === 1'b1) begin
      if (q32.size() == 0) begin
        chk("resp32_unexpected", 64'(resp_valid), 64'd0);
      end else begin
        e32 = q32.pop_front();
        chk($sformatf("t%0d_rdata", e32.id), 64'(resp_rdata), e32.rdata);
        chk($sformatf("t%0d_err", e32.id), 64'(resp_err), 64'(e32.err));
        if (e32.err == 2'd1 || e32.err == 2'd2)
          chk($sformatf("t%0d_badvaddr", e32.id), 64'(badvaddr), 64'(e32.bad));
      end
    end
  end

  // Monitor for the 64-bit unit
  always @(negedge clk) begin
    if (rst === 1'b1 && w_resp_valid === 1'b1) begin
      if (q64.size() == 0) begin
        chk("resp64_unexpected", 64'(w_resp_valid), 64'd0);
      end else begin
        e64 = q64.pop_front();
        chk($sformatf("w%0d_rdata", e64.id), w_resp_rdata, e64.rdata);
        chk($sformatf("w%0d_err", e64.id), 64'(w_resp_err), 64'(e64.err));
      end
    end
  end

  // kill: 0 none, 1 flush on first BUS cycle, 2 flush in the RESP cycle
  task automatic run(input logic we, input logic [1:0] size, input logic sgn,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input int ack_at, input logic [31:0] rdata, input int kill,
                     input int exp_bus, input logic [31:0] exp_maddr,
                     input logic [3:0] exp_wen, input logic [31:0] exp_wdata,
                     input logic [31:0] exp_rdata, input logic [1:0] exp_err,
                     input logic [31:0] exp_bad, input int id);
    int bus_cyc;
    int stall_cyc;
    bit reached;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    chk($sformatf("t%0d_ready", id), 64'(req_ready), 64'd1);
    stall_cyc = (stall === 1'b1) ? 1 : 0;
    if (kill == 0) q32.push_back('{rdata: 64'(exp_rdata), err: exp_err, bad: exp_bad, id: id});
    @(posedge clk); #1;
    req_valid = 1'b0;
    bus_cyc = 0;
    reached = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (stall === 1'b1) stall_cyc++;
      if (mem_en !== 1'b1) begin
        reached = 1'b1;
        break;
      end
      bus_cyc++;
      if (bus_cyc == 1) begin
        chk($sformatf("t%0d_mem_addr", id), 64'(mem_addr), 64'(exp_maddr));
        chk($sformatf("t%0d_mem_wen", id), 64'(mem_wen), 64'(exp_wen));
        if (we) chk($sformatf("t%0d_mem_wdata", id), 64'(mem_wdata), 64'(exp_wdata));
        if (kill == 1) flush = 1'b1;
      end
      if (bus_cyc == ack_at) begin
        mem_ack = 1'b1;
        mem_rdata = rdata;
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
      flush = 1'b0;
      if (bus_cyc == ack_at && kill == 2) flush = 1'b1;
    end
    chk($sformatf("t%0d_reached_resp", id), 64'(reached), 64'd1);
    chk($sformatf("t%0d_bus_cycles", id), 64'(bus_cyc), 64'(exp_bus));
    chk($sformatf("t%0d_stall_cycles", id), 64'(stall_cyc), 64'(exp_bus + 1));
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk($sformatf("t%0d_idle_ready", id), 64'(req_ready), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    bit seen;
    rst = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    w_req_valid = 1'b0; w_req_wdata = '0; w_mem_ack = 1'b0; w_mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_stall", 64'(stall), 64'd0);
    chk("reset_mem_en", 64'(mem_en), 64'd0);
    chk("reset_mem_wen", 64'(mem_wen), 64'd0);
    chk("reset_mem_addr", 64'(mem_addr), 64'd0);
    chk("reset_resp_valid", 64'(resp_valid), 64'd0);
    chk("reset_resp_err", 64'(resp_err), 64'd0);
    chk("reset_resp_rdata", 64'(resp_rdata), 64'd0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    //   we  sz  sg addr          wdata         ack rdata         kill bus maddr         wen      wdata         rdata         err  bad           id
    run(1'b0, 2'd0, 1'b1, 32'h1003, 32'h0,        3, 32'h80FF_FFFF, 0, 3, 32'h1000, 4'b0000, 32'h0,        32'hFFFF_FF80, 2'd0, 32'h0,    1);
    run(1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000_ABCD, 1, 32'hFFFF_FFFF, 0, 1, 32'h2000, 4'b1100, 32'hABCD_ABCD, 32'h0,        2'd0, 32'h0,    2);
    run(1'b0, 2'd2, 1'b0, 32'h3001, 32'h0,        0, 32'h0,         0, 0, 32'h0,    4'b0000, 32'h0,        32'h0,        2'd1, 32'h3001, 3);
    run(1'b0, 2'd2, 1'b0, 32'h4000, 32'h0,        0, 32'h0,         0, 4, 32'h4000, 4'b0000, 32'h0,        32'h0,        2'd2, 32'h4000, 4);
    run(1'b0, 2'd2, 1'b0, 32'h4000, 32'h0,        4, 32'h1234_5678, 0, 4, 32'h4000, 4'b0000, 32'h0,        32'h1234_5678, 2'd0, 32'h0,    5);
    run(1'b0, 2'd3, 1'b0, 32'h0008, 32'h0,        0, 32'h0,         0, 0, 32'h0,    4'b0000, 32'h0,        32'h0,        2'd3, 32'h0008, 6);
    run(1'b0, 2'd1, 1'b0, 32'h1002, 32'h0,        1, 32'h8001_1234, 0, 1, 32'h1000, 4'b0000, 32'h0,        32'h0000_8001, 2'd0, 32'h0,    7);
    run(1'b0, 2'd1, 1'b1, 32'h1002, 32'h0,        1, 32'h8001_1234, 0, 1, 32'h1000, 4'b0000, 32'h0,        32'hFFFF_8001, 2'd0, 32'h0,    8);
    run(1'b1, 2'd0, 1'b0, 32'h4001, 32'h1234_5678, 2, 32'h0,         0, 2, 32'h4000, 4'b0010, 32'h7878_7878, 32'h0,        2'd0, 32'h0,    9);
    run(1'b1, 2'd2, 1'b0, 32'h5004, 32'hCAFE_F00D, 1, 32'h0,         0, 1, 32'h5004, 4'b1111, 32'hCAFE_F00D, 32'h0,        2'd0, 32'h0,    10);
    run(1'b0, 2'd1, 1'b0, 32'h6001, 32'h0,        0, 32'h0,         0, 0, 32'h0,    4'b0000, 32'h0,        32'h0,        2'd1, 32'h6001, 11);
    run(1'b0, 2'd2, 1'b0, 32'h7000, 32'h0,        2, 32'h5555_5555, 1, 2, 32'h7000, 4'b0000, 32'h0,        32'h0,        2'd0, 32'h0,    12);
    run(1'b0, 2'd2, 1'b0, 32'h7004, 32'h0,        1, 32'h6666_6666, 2, 1, 32'h7004, 4'b0000, 32'h0,        32'h0,        2'd0, 32'h0,    13);
    run(1'b0, 2'd0, 1'b0, 32'h9002, 32'h0,        1, 32'h00A5_0000, 0, 1, 32'h9000, 4'b0000, 32'h0,        32'h0000_00A5, 2'd0, 32'h0,    14);

    // Flush in IDLE blocks acceptance; response registers keep their last values
    @(posedge clk); #1;
    req_valid = 1'b1; flush = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'hA000;
    @(negedge clk);
    chk("idle_flush_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("idle_flush_mem_en", 64'(mem_en), 64'd0);
    chk("idle_flush_ready", 64'(req_ready), 64'd1);
    chk("hold_resp_rdata", 64'(resp_rdata), 64'h0000_00A5);
    chk("hold_resp_err", 64'(resp_err), 64'd0);

    // Reset pulse in the middle of a store's BUS phase
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'hB000; req_wdata = 32'h1122_3344;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstbus_mem_en_before", 64'(mem_en), 64'd1);
    rst = 1'b0;
    #1;
    chk("rstbus_mem_en", 64'(mem_en), 64'd0);
    chk("rstbus_mem_wen", 64'(mem_wen), 64'd0);
    chk("rstbus_mem_addr", 64'(mem_addr), 64'd0);
    chk("rstbus_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rstbus_resp_rdata", 64'(resp_rdata), 64'd0);
    chk("rstbus_resp_err", 64'(resp_err), 64'd0);
    chk("rstbus_badvaddr", 64'(badvaddr), 64'd0);
    chk("rstbus_stall", 64'(stall), 64'd0);
    chk("rstbus_ready", 64'(req_ready), 64'd1);
    chk("rstbus_resp_valid", 64'(resp_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_ready", 64'(req_ready), 64'd1);
    chk("late_ack_mem_en", 64'(mem_en), 64'd0);

    // 64-bit unit: unsigned dword load keeps the data unchanged
    @(posedge clk); #1;
    w_req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_signed = 1'b0; req_addr = 32'h8;
    q64.push_back('{rdata: 64'h8000_0000_0000_0001, err: 2'd0, bad: 32'h0, id: 1});
    @(posedge clk); #1;
    w_req_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (w_mem_en === 1'b1) begin
        seen = 1'b1;
        chk("w1_mem_addr", 64'(w_mem_addr), 64'h8);
        chk("w1_mem_wen", 64'(w_mem_wen), 64'h0);
        w_mem_ack = 1'b1; w_mem_rdata = 64'h8000_0000_0000_0001;
        @(posedge clk); #1;
        w_mem_ack = 1'b0;
        break;
      end
    end
    chk("w1_bus_seen", 64'(seen), 64'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);

    chk("q32_drained", 64'(q32.size()), 64'd0);
    chk("q64_drained", 64'(q64.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning data bus width, legal values 32 or 64.
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of BUS cycles to wait for mem_ack; 0 disables the timeout.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  pipeline presents a load/store.
REQ-007 req_ready  output  1  unit can accept a request.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = dword.
REQ-010 req_signed  input  1  load sign-extends when 1, zero-extends when 0.
REQ-011 req_addr  input  ADDR_W  byte address.
REQ-012 req_wdata  input  DATA_W  store data, right-aligned.
REQ-013 flush  input  1  pipeline kill of the in-flight access.
REQ-014 stall  output  1  hold the upstream pipeline.
REQ-015 resp_valid  output  1  one-cycle completion pulse.
REQ-016 resp_rdata  output  DATA_W  extended load data; 0 for stores and for errors.
REQ-017 resp_err  output  2  0 = ok, 1 = misaligned, 2 = timeout, 3 = illegal size.
REQ-018 badvaddr  output  ADDR_W  faulting address; valid when resp_err is nonzero.
REQ-019 mem_en  output  1  bus request.
REQ-020 mem_wen  output  DATA_W/8  byte-lane write strobes.
REQ-021 mem_addr  output  ADDR_W  address with the low log2(DATA_W/8) bits forced to 0.
REQ-022 mem_wdata  output  DATA_W  lane-replicated store data.
REQ-023 mem_rdata  input  DATA_W  read data, sampled on mem_ack.
REQ-024 mem_ack  input  1  bus completion, single-cycle pulse.

Function
REQ-025 The FSM SHALL have the states IDLE, BUS and RESP; req_ready SHALL be 1 only in IDLE.
REQ-026 In IDLE, req_valid=1 with flush=0 SHALL accept the request and latch addr, size, we, signed and wdata.
REQ-027 An accepted request with req_size=3 and DATA_W=32 SHALL go to RESP with resp_err=3 and no bus activity.
REQ-028 An accepted request with addr mod 2^size != 0 SHALL go to RESP with resp_err=1, badvaddr=addr and no bus activity.
REQ-029 Otherwise an accepted request SHALL go to BUS.
REQ-030 In BUS, mem_en=1 SHALL hold, and mem_addr, mem_wen and mem_wdata SHALL be held stable until exit from BUS.
REQ-031 mem_wen SHALL be the size mask ((1<<2^size)-1) shifted left by the byte offset when we=1, and all zeros when we=0.
REQ-032 mem_wdata SHALL be the low 2^size bytes of wdata replicated across all lanes.
REQ-033 mem_ack in BUS SHALL move the FSM to RESP.
REQ-034 On mem_ack for a load, the unit SHALL register the lanes at the byte offset of mem_rdata, extended per signed, into resp_rdata.
REQ-035 A 10-bit-or-wider wait counter SHALL clear on entry to BUS and increment each BUS cycle.
REQ-036 When the wait counter reaches TIMEOUT (TIMEOUT != 0) without mem_ack, the unit SHALL drop mem_en and go to RESP with resp_err=2 and badvaddr=addr.
REQ-037 mem_ack in the same cycle as the timeout SHALL win, giving resp_err=0.
REQ-038 resp_valid SHALL be 1 for exactly the one RESP cycle, after which the FSM SHALL return to IDLE; a new request is not accepted in RESP.
REQ-039 stall SHALL equal (IDLE and req_valid and not flush) or BUS; stall SHALL be 0 in RESP.
REQ-040 Minimum latency SHALL be 2 cycles: accept at T, mem_ack at T+1, resp_valid at T+2.
REQ-041 flush in IDLE SHALL block acceptance.
REQ-042 flush while in BUS SHALL NOT abort the bus access; the unit SHALL wait for mem_ack or timeout and then suppress resp_valid for that access.
REQ-043 flush in RESP SHALL suppress resp_valid.
REQ-044 The outputs resp_rdata, resp_err and badvaddr SHALL hold their values until the next RESP.

Reset
REQ-045 rst=0 SHALL asynchronously force IDLE and clear the wait counter, with mem_en=0, mem_wen=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_rdata=0, resp_err=0, badvaddr=0, stall=0 and req_ready=1.
REQ-046 Reset asserted in BUS SHALL drop mem_en immediately; a mem_ack arriving after reset release SHALL be ignored in IDLE.

Verification
REQ-047 DATA_W=32, load byte signed at addr 0x1003, mem_rdata=0x80FFFFFF acked after 3 cycles -> mem_addr=0x1000, resp_rdata=0xFFFFFF80, resp_err=0, stall high 4 cycles.
REQ-048 Store half at 0x2002, wdata=0x0000ABCD -> mem_wen=4'b1100, mem_wdata=0xABCDABCD, resp_valid 1 cycle, resp_rdata=0.
REQ-049 Load word at 0x3001 -> no mem_en, resp_err=1, badvaddr=0x3001 at T+1.
REQ-050 TIMEOUT=4, no ack -> mem_en drops after 4 BUS cycles, resp_err=2; repeat with ack on the 4th cycle -> resp_err=0.
REQ-051 DATA_W=64, load dword unsigned at 0x8, rdata=0x8000000000000001 -> resp_rdata unchanged; the same request with DATA_W=32 -> resp_err=3.
REQ-052 flush during BUS, then ack -> no resp_valid; rst pulse mid-BUS -> all outputs at reset values within the same cycle.
